// File: rtl/ibex_pext_dual_word_seq_if.sv
// Issue/writeback bus for the RV32 P-ext 64-bit add/sub sequencer.
// master = issue side + register file, slave = sequencer.
interface ibex_pext_dual_word_seq_if;
  logic        en_i;
  logic [7:0]  operator_i;
  logic [31:0] operand_a_i;
  logic [31:0] operand_b_i;
  logic        flush_i;
  logic        wb_ready_i;
  logic        rf_hi_sel_o;
  logic        rf_we_o;
  logic [31:0] rf_wdata_o;
  logic        busy_o;
  logic        valid_o;
  logic        ov_set_o;
  logic        illegal_o;

  modport master (
    output en_i, operator_i, operand_a_i, operand_b_i,
    output flush_i, wb_ready_i,
    input  rf_hi_sel_o, rf_we_o, rf_wdata_o,
    input  busy_o, valid_o, ov_set_o, illegal_o
  );

  modport slave (
    input  en_i, operator_i, operand_a_i, operand_b_i,
    input  flush_i, wb_ready_i,
    output rf_hi_sel_o, rf_we_o, rf_wdata_o,
    output busy_o, valid_o, ov_set_o, illegal_o
  );
endinterface

// File: rtl/ibex_pext_dual_word_seq.sv
// RV32 P-ext 64-bit add/sub sequencer: reads even/odd register
// pairs over two cycles, writes the 64-bit result as two words.
module ibex_pext_dual_word_seq #(
  parameter bit SupportHalving    = 1'b1,
  parameter bit SupportSaturating = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  ibex_pext_dual_word_seq_if.slave bus
);

  localparam logic [7:0] ZPN_ADD64   = 8'h10;
  localparam logic [7:0] ZPN_SUB64   = 8'h11;
  localparam logic [7:0] ZPN_RADD64  = 8'h12;
  localparam logic [7:0] ZPN_URADD64 = 8'h13;
  localparam logic [7:0] ZPN_RSUB64  = 8'h14;
  localparam logic [7:0] ZPN_URSUB64 = 8'h15;
  localparam logic [7:0] ZPN_KADD64  = 8'h16;
  localparam logic [7:0] ZPN_UKADD64 = 8'h17;
  localparam logic [7:0] ZPN_KSUB64  = 8'h18;
  localparam logic [7:0] ZPN_UKSUB64 = 8'h19;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HI,
    S_WB_LO,
    S_WB_HI
  } state_e;

  state_e      r_state;
  state_e      w_next;

  logic [31:0] r_lo;
  logic        r_carry;
  logic        r_sub;
  logic        r_sgn;
  logic        r_halv;
  logic        r_sat;
  logic [63:0] r_res;
  logic        r_ov;

  logic        w_sup;
  logic        w_sub;
  logic        w_sgn;
  logic        w_halv;
  logic        w_sat;

  logic [31:0] w_b_lo;
  logic [32:0] w_lo;
  logic [32:0] w_a_ext;
  logic [32:0] w_b_ext;
  logic [32:0] w_b_hi;
  logic [32:0] w_hi;
  logic [64:0] w_r;
  logic [63:0] w_res;
  logic        w_ov;

  logic        w_start;
  logic        w_cap;
  logic        w_sel;
  logic        w_we;
  logic [31:0] w_wdata;
  logic        w_valid;
  logic        w_ov_set;
  logic        w_illegal;

  // Operator decode: support, direction, signedness, result class.
  always_comb begin
    w_sup  = 1'b0;
    w_sub  = 1'b0;
    w_sgn  = 1'b1;
    w_halv = 1'b0;
    w_sat  = 1'b0;
    case (bus.operator_i)
      ZPN_ADD64: begin
        w_sup = 1'b1;
      end
      ZPN_SUB64: begin
        w_sup = 1'b1;
        w_sub = 1'b1;
      end
      ZPN_RADD64: begin
        w_sup  = SupportHalving;
        w_halv = 1'b1;
      end
      ZPN_URADD64: begin
        w_sup  = SupportHalving;
        w_halv = 1'b1;
        w_sgn  = 1'b0;
      end
      ZPN_RSUB64: begin
        w_sup  = SupportHalving;
        w_halv = 1'b1;
        w_sub  = 1'b1;
      end
      ZPN_URSUB64: begin
        w_sup  = SupportHalving;
        w_halv = 1'b1;
        w_sub  = 1'b1;
        w_sgn  = 1'b0;
      end
      ZPN_KADD64: begin
        w_sup = SupportSaturating;
        w_sat = 1'b1;
      end
      ZPN_UKADD64: begin
        w_sup = SupportSaturating;
        w_sat = 1'b1;
        w_sgn = 1'b0;
      end
      ZPN_KSUB64: begin
        w_sup = SupportSaturating;
        w_sat = 1'b1;
        w_sub = 1'b1;
      end
      ZPN_UKSUB64: begin
        w_sup = SupportSaturating;
        w_sat = 1'b1;
        w_sub = 1'b1;
        w_sgn = 1'b0;
      end
      default: begin
        w_sup = 1'b0;
      end
    endcase
  end

  // Low word adds zero-extended; its carry feeds the high word.
  assign w_b_lo = w_sub ? ~bus.operand_b_i : bus.operand_b_i;
  assign w_lo   = {1'b0, bus.operand_a_i}
                + {1'b0, w_b_lo}
                + {32'd0, w_sub};

  // High word extends to 33 bits so R holds the full 65-bit result.
  assign w_a_ext = {r_sgn & bus.operand_a_i[31], bus.operand_a_i};
  assign w_b_ext = {r_sgn & bus.operand_b_i[31], bus.operand_b_i};
  assign w_b_hi  = r_sub ? ~w_b_ext : w_b_ext;
  assign w_hi    = w_a_ext + w_b_hi + {32'd0, r_carry};
  assign w_r     = {w_hi, r_lo};

  // Final 64-bit result: wrap, halve, or saturate.
  always_comb begin
    w_res = w_r[63:0];
    w_ov  = 1'b0;
    if (r_halv) begin
      w_res = w_r[64:1];
    end else if (r_sat) begin
      if (r_sgn) begin
        if (w_r[64] != w_r[63]) begin
          w_ov  = 1'b1;
          w_res = w_r[64] ? {1'b1, 63'd0} : {1'b0, {63{1'b1}}};
        end
      end else if (w_r[64]) begin
        w_ov  = 1'b1;
        w_res = r_sub ? 64'd0 : {64{1'b1}};
      end
    end
  end

  // Next state and outputs; kill (flush/reset) overrides last.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_cap     = 1'b0;
    w_sel     = 1'b0;
    w_we      = 1'b0;
    w_wdata   = 32'd0;
    w_valid   = 1'b0;
    w_ov_set  = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.en_i) begin
          if (!w_sup) begin
            w_illegal = 1'b1;
          end else if (!bus.flush_i) begin
            w_start = 1'b1;
            w_next  = S_HI;
          end
        end
      end
      S_HI: begin
        w_sel  = 1'b1;
        w_cap  = 1'b1;
        w_next = S_WB_LO;
      end
      S_WB_LO: begin
        w_we    = 1'b1;
        w_wdata = r_res[31:0];
        if (bus.wb_ready_i) begin
          w_next = S_WB_HI;
        end
      end
      S_WB_HI: begin
        w_sel   = 1'b1;
        w_we    = 1'b1;
        w_wdata = r_res[63:32];
        if (bus.wb_ready_i) begin
          w_valid  = 1'b1;
          w_ov_set = r_ov;
          w_next   = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (bus.flush_i || rst_i) begin
      w_next   = S_IDLE;
      w_start  = 1'b0;
      w_cap    = 1'b0;
      w_we     = 1'b0;
      w_valid  = 1'b0;
      w_ov_set = 1'b0;
    end
    if (rst_i) begin
      w_illegal = 1'b0;
    end
  end

  // State, low-half partial sum, op class and final result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_lo    <= 32'd0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_sgn   <= 1'b0;
      r_halv  <= 1'b0;
      r_sat   <= 1'b0;
      r_res   <= 64'd0;
      r_ov    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_lo    <= w_lo[31:0];
        r_carry <= w_lo[32];
        r_sub   <= w_sub;
        r_sgn   <= w_sgn;
        r_halv  <= w_halv;
        r_sat   <= w_sat;
      end
      if (w_cap) begin
        r_res <= w_res;
        r_ov  <= w_ov;
      end
    end
  end

  assign bus.rf_hi_sel_o = w_sel;
  assign bus.rf_we_o     = w_we;
  assign bus.rf_wdata_o  = w_wdata;
  assign bus.busy_o      = (r_state != S_IDLE);
  assign bus.valid_o     = w_valid;
  assign bus.ov_set_o    = w_ov_set;
  assign bus.illegal_o   = w_illegal;

endmodule

// File: tb/tb_ibex_pext_dual_word_seq.sv
// Bench for ibex_pext_dual_word_seq: vector table, corner
// sequences and random ops against a behavioural model.
module tb_ibex_pext_dual_word_seq;

  localparam logic [7:0] ADD64   = 8'h10;
  localparam logic [7:0] SUB64   = 8'h11;
  localparam logic [7:0] RADD64  = 8'h12;
  localparam logic [7:0] URADD64 = 8'h13;
  localparam logic [7:0] RSUB64  = 8'h14;
  localparam logic [7:0] URSUB64 = 8'h15;
  localparam logic [7:0] KADD64  = 8'h16;
  localparam logic [7:0] UKADD64 = 8'h17;
  localparam logic [7:0] KSUB64  = 8'h18;
  localparam logic [7:0] UKSUB64 = 8'h19;
  localparam logic [7:0] SMAR64  = 8'h20;

  logic clk;
  logic rst;
  logic [63:0] cur_a;
  logic [63:0] cur_b;
  int n_chk;
  int n_pass;

  ibex_pext_dual_word_seq_if u_if ();
  ibex_pext_dual_word_seq_if u_if0 ();

  // Register file model: serve the half selected by the DUT.
  assign u_if.operand_a_i = u_if.rf_hi_sel_o ? cur_a[63:32] : cur_a[31:0];
  assign u_if.operand_b_i = u_if.rf_hi_sel_o ? cur_b[63:32] : cur_b[31:0];
  assign u_if0.operand_a_i = 32'd0;
  assign u_if0.operand_b_i = 32'd0;
  assign u_if0.flush_i = 1'b0;
  assign u_if0.wb_ready_i = 1'b1;

  ibex_pext_dual_word_seq u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u_if.slave)
  );

  ibex_pext_dual_word_seq #(
    .SupportHalving    (1'b0),
    .SupportSaturating (1'b0)
  ) u_dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u_if0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: exact integer arithmetic with range checks.
  function automatic void model(input logic [7:0] op,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output bit ov);
    logic signed [65:0] sa, sb, s, smax, smin;
    logic [65:0] ua, ub, u;
    sa = {{2{a[63]}}, a};
    sb = {{2{b[63]}}, b};
    ua = {2'b00, a};
    ub = {2'b00, b};
    smax = {3'b000, {63{1'b1}}};
    smin = {3'b111, 63'd0};
    r = 64'd0;
    ov = 1'b0;
    case (op)
      ADD64: r = a + b;
      SUB64: r = a - b;
      RADD64: begin s = sa + sb; s = s >>> 1; r = s[63:0]; end
      URADD64: begin u = ua + ub; r = u[64:1]; end
      RSUB64: begin s = sa - sb; s = s >>> 1; r = s[63:0]; end
      URSUB64: begin
        s = $signed(ua) - $signed(ub);
        s = s >>> 1;
        r = s[63:0];
      end
      KADD64, KSUB64: begin
        s = (op == KADD64) ? sa + sb : sa - sb;
        if (s > smax) begin r = smax[63:0]; ov = 1'b1; end
        else if (s < smin) begin r = smin[63:0]; ov = 1'b1; end
        else r = s[63:0];
      end
      UKADD64: begin
        u = ua + ub;
        if (u > {2'b00, {64{1'b1}}}) begin r = '1; ov = 1'b1; end
        else r = u[63:0];
      end
      UKSUB64: begin
        if (a < b) begin r = 64'd0; ov = 1'b1; end
        else r = a - b;
      end
      default: r = 64'd0;
    endcase
  endfunction

  // One op start to completion; collects accepted writes.
  task automatic run_txn(input logic [7:0] op, input logic [63:0] a,
                         input logic [63:0] b, input int stall_pct,
                         output logic [63:0] got, output bit gov,
                         output int lat, output int nwr, output bit ord_ok);
    int cyc;
    bit done;
    got = 64'd0; gov = 1'b0; lat = 0; nwr = 0; ord_ok = 1'b1; done = 1'b0;
    @(negedge clk);
    cur_a = a;
    cur_b = b;
    u_if.operator_i = op;
    u_if.en_i = 1'b1;
    u_if.wb_ready_i = 1'b1;
    @(negedge clk);
    u_if.en_i = 1'b0;
    cyc = 2;
    while (!done && cyc < 60) begin
      u_if.wb_ready_i = ($urandom_range(99) >= stall_pct);
      #1;
      if (u_if.rf_we_o && u_if.wb_ready_i) begin
        if (u_if.rf_hi_sel_o != (nwr != 0)) ord_ok = 1'b0;
        if (u_if.rf_hi_sel_o) got[63:32] = u_if.rf_wdata_o;
        else got[31:0] = u_if.rf_wdata_o;
        nwr++;
      end
      if (u_if.valid_o) begin
        done = 1'b1;
        gov = u_if.ov_set_o;
        lat = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    u_if.wb_ready_i = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    bit          ov;
  } vec_t;

  vec_t tbl[12];
  logic [7:0] ops[10];
  logic [63:0] edges[6];

  initial begin
    logic [63:0] got, er, a, b;
    bit gov, eov, ord_ok;
    int lat, nwr, cnt;
    logic [7:0] op;

    tbl[0]  = '{ADD64,   64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000, 0};
    tbl[1]  = '{KADD64,  64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1};
    tbl[2]  = '{KSUB64,  64'h8000_0000_0000_0000, 64'h1, 64'h8000_0000_0000_0000, 1};
    tbl[3]  = '{UKSUB64, 64'h5, 64'h7, 64'h0, 1};
    tbl[4]  = '{UKADD64, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    tbl[5]  = '{RADD64,  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                64'h8000_0000_0000_0000, 0};
    tbl[6]  = '{URADD64, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                64'h8000_0000_0000_0000, 0};
    tbl[7]  = '{RSUB64,  64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    tbl[8]  = '{SUB64,   64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    tbl[9]  = '{KADD64,  64'h1, 64'h2, 64'h3, 0};
    tbl[10] = '{URSUB64, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 0};
    tbl[11] = '{UKSUB64, 64'h1_0000_0000, 64'h1, 64'h0000_0000_FFFF_FFFF, 0};

    ops = '{ADD64, SUB64, RADD64, URADD64, RSUB64,
            URSUB64, KADD64, UKADD64, KSUB64, UKSUB64};
    edges = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 64'h0000_0000_FFFF_FFFF, 64'h1};

    n_chk = 0; n_pass = 0;
    cur_a = 64'd0; cur_b = 64'd0;
    u_if.en_i = 1'b0; u_if.operator_i = 8'h0;
    u_if.flush_i = 1'b0; u_if.wb_ready_i = 1'b1;
    u_if0.en_i = 1'b0; u_if0.operator_i = 8'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_outputs", 64'({u_if.busy_o, u_if.rf_we_o, u_if.valid_o,
        u_if.ov_set_o, u_if.rf_hi_sel_o, u_if.illegal_o}), 64'd0);
    chk("reset_wdata", 64'(u_if.rf_wdata_o), 64'd0);

    foreach (tbl[i]) begin
      run_txn(tbl[i].op, tbl[i].a, tbl[i].b, 0, got, gov, lat, nwr, ord_ok);
      chk($sformatf("vec%0d_result", i), got, tbl[i].exp);
      chk($sformatf("vec%0d_ov", i), 64'(gov), 64'(tbl[i].ov));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      chk($sformatf("vec%0d_writes", i), 64'({nwr[3:0], ord_ok}), 64'h5);
    end

    // Writeback stall: low write held stable for three cycles.
    @(negedge clk);
    cur_a = 64'h0000_0001_0000_0002; cur_b = 64'h3;
    u_if.operator_i = ADD64; u_if.en_i = 1'b1;
    @(negedge clk);
    u_if.en_i = 1'b0;
    @(negedge clk);
    u_if.wb_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_hold", k), 64'({u_if.busy_o, u_if.rf_we_o,
          u_if.rf_hi_sel_o, u_if.valid_o, u_if.rf_wdata_o}),
          64'({4'b1100, 32'h5}));
      @(negedge clk);
    end
    u_if.wb_ready_i = 1'b1;
    @(negedge clk);
    #1;
    chk("stall_hi_write", 64'({u_if.rf_we_o, u_if.rf_hi_sel_o, u_if.valid_o,
        u_if.rf_wdata_o}), 64'({3'b111, 32'h1}));
    @(negedge clk);
    #1;
    chk("stall_idle_after", 64'(u_if.busy_o), 64'd0);

    // Flush in HI: back to IDLE, no writes follow.
    u_if.operator_i = ADD64; u_if.en_i = 1'b1;
    @(negedge clk);
    u_if.en_i = 1'b0; u_if.flush_i = 1'b1;
    #1;
    chk("flush_hi_we", 64'(u_if.rf_we_o), 64'd0);
    @(negedge clk);
    u_if.flush_i = 1'b0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (u_if.rf_we_o || u_if.valid_o || u_if.busy_o) cnt++;
      @(negedge clk);
    end
    chk("flush_hi_quiet", 64'(cnt), 64'd0);

    // Flush in WB_LO forces the write strobe low that cycle.
    u_if.operator_i = KADD64; u_if.en_i = 1'b1;
    @(negedge clk);
    u_if.en_i = 1'b0;
    @(negedge clk);
    #1;
    chk("wblo_we_before_flush", 64'(u_if.rf_we_o), 64'd1);
    u_if.flush_i = 1'b1;
    #1;
    chk("flush_wblo_we", 64'({u_if.rf_we_o, u_if.valid_o}), 64'd0);
    @(negedge clk);
    u_if.flush_i = 1'b0;
    #1;
    chk("flush_wblo_idle", 64'(u_if.busy_o), 64'd0);

    // Illegal ops: unknown encoding and disabled classes.
    @(negedge clk);
    u_if.operator_i = SMAR64; u_if.en_i = 1'b1;
    u_if0.operator_i = RADD64; u_if0.en_i = 1'b1;
    #1;
    chk("illegal_smar64", 64'(u_if.illegal_o), 64'd1);
    chk("illegal_radd64_nohalv", 64'(u_if0.illegal_o), 64'd1);
    @(negedge clk);
    u_if0.operator_i = KSUB64;
    #1;
    chk("illegal_busy", 64'({u_if.busy_o, u_if0.busy_o}), 64'd0);
    chk("illegal_ksub64_nosat", 64'(u_if0.illegal_o), 64'd1);
    u_if0.operator_i = ADD64;
    #1;
    chk("legal_add64_nosat", 64'(u_if0.illegal_o), 64'd0);
    @(negedge clk);
    u_if.en_i = 1'b0; u_if0.en_i = 1'b0;
    #1;
    chk("add64_started_nosat", 64'(u_if0.busy_o), 64'd1);
    repeat (4) @(negedge clk);

    // Reset in WB_HI: no completion, everything cleared.
    cur_a = 64'h7FFF_FFFF_FFFF_FFFF; cur_b = 64'h1;
    u_if.operator_i = KADD64; u_if.en_i = 1'b1;
    @(negedge clk);
    u_if.en_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_wbhi_no_valid", 64'({u_if.valid_o, u_if.ov_set_o,
        u_if.rf_we_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wbhi_outputs", 64'({u_if.busy_o, u_if.rf_we_o, u_if.valid_o,
        u_if.ov_set_o, u_if.rf_hi_sel_o, u_if.illegal_o,
        u_if.rf_wdata_o}), 64'd0);

    // Random ops and operands with random writeback stalls.
    for (int t = 0; t < 80; t++) begin
      op = ops[$urandom_range(9)];
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(3) == 0) a = edges[$urandom_range(5)];
      if ($urandom_range(3) == 0) b = edges[$urandom_range(5)];
      model(op, a, b, er, eov);
      run_txn(op, a, b, 30, got, gov, lat, nwr, ord_ok);
      chk($sformatf("rnd%0d_op%h_result", t, op), got, er);
      chk($sformatf("rnd%0d_op%h_ov", t, op), 64'(gov), 64'(eov));
      chk($sformatf("rnd%0d_done", t), 64'({lat != 0, nwr[3:0], ord_ok}),
          64'h25);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ibex_pext_dual_word_seq.md
Name: ibex_pext_dual_word_seq

Overview:
- Execution-side consumer of `zpn_op_e` for the 64-bit add/sub family on RV32.
- The decoder issues an op from the `ibex_pkg_pext` set. This block fetches each 64-bit operand as an even/odd register pair over two cycles, computes the plain, halving or saturating result, then writes the 64-bit result back as two 32-bit register writes.
- It sits beside the P-ext ALU in EX. It drives the register-pair half selects and reports vxsat (OV) set events to the CSR logic.

Parameters:
- SupportHalving, 1, 0 makes RADD64/URADD64/RSUB64/URSUB64 illegal.
- SupportSaturating, 1, 0 makes KADD64/UKADD64/KSUB64/UKSUB64 illegal.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- en_i  in  1  start request; sampled only in IDLE.
- operator_i  in  8  `ibex_pkg_pext::zpn_op_e`.
- operand_a_i  in  32  rs1 half selected by rf_hi_sel_o.
- operand_b_i  in  32  rs2 half selected by rf_hi_sel_o.
- flush_i  in  1  abort; pipeline kill.
- wb_ready_i  in  1  writeback port accepts rf_wdata_o this cycle.
- rf_hi_sel_o  out  1  0 = even (low) registers, 1 = odd (high) registers; for both read and write.
- rf_we_o  out  1  register write strobe.
- rf_wdata_o  out  32  write data.
- busy_o  out  1  operation in progress (stall ID).
- valid_o  out  1  1-cycle pulse on completion.
- ov_set_o  out  1  1-cycle pulse: set vxsat.
- illegal_o  out  1  combinational: en_i with unsupported or disabled op while IDLE.

Behaviour:
- Supported ops: ADD64, SUB64, RADD64, URADD64, RSUB64, URSUB64, KADD64, UKADD64, KSUB64, UKSUB64. Signedness is signed for ADD/SUB/R/K and unsigned for UR/UK. ADD64/SUB64 wrap; signedness is irrelevant to their result.
- States: IDLE, HI, WB_LO, WB_HI.
- IDLE:
  - rf_hi_sel_o=0.
  - On en_i & supported & !flush_i: compute lo = {0,a_lo} + {0,b_lo or ~b_lo} + sub (33-bit).
  - Register lo[31:0], carry = lo[32], op class. Go to HI.
  - Unsupported op: illegal_o=1, stay IDLE, no other output.
- HI:
  - rf_hi_sel_o=1.
  - Compute hi = ext(a_hi) + ext(b_hi or ~b_hi) + carry (33-bit). ext is sign- or zero-extension per signedness; for sub, ext is applied before inversion.
  - Full 65-bit result R = {hi, lo}.
  - Halving: result = R[64:1]. The low word becomes {hi[0], lo[31:1]}. Round toward −inf, no OV.
  - Signed saturating: overflow when R[64]≠R[63]. Result 0x7FFF_FFFF_FFFF_FFFF if R[64]=0, else 0x8000_0000_0000_0000.
  - Unsigned saturating add: overflow when R[64]=1; result all-ones.
  - Unsigned saturating sub: overflow when R[64]=1 (borrow); result 0.
  - Register the 64-bit result and ov flag. Go to WB_LO.
- WB_LO:
  - rf_hi_sel_o=0, rf_we_o=1, rf_wdata_o = result[31:0].
  - Advance to WB_HI only when wb_ready_i; otherwise hold all outputs.
- WB_HI:
  - rf_hi_sel_o=1, rf_we_o=1, rf_wdata_o = result[63:32].
  - On wb_ready_i: valid_o=1, ov_set_o = ov, go to IDLE.
- Latency:
  - Start to valid_o is 4 cycles with wb_ready_i held 1.
  - A new en_i is accepted the cycle after valid_o. A back-to-back start in the same cycle as valid_o is not allowed.
- busy_o = (state≠IDLE).
- flush_i in any state:
  - Next state IDLE.
  - rf_we_o is forced 0 that cycle; valid_o and ov_set_o are 0.
  - A low write already accepted is not undone; EX kill semantics apply.
- rst_i: state=IDLE, registered result/carry/ov=0.
- Reset values of outputs: rf_we_o=0, valid_o=0, ov_set_o=0, busy_o=0, rf_hi_sel_o=0, rf_wdata_o=0, illegal_o=0.
- rst_i mid-operation behaves identically to flush, with registers cleared.
- Operands are sampled only in IDLE (low halves) and HI (high halves); inputs in WB states are ignored.
- en_i in non-IDLE states is ignored.
- ov_set_o is never asserted for wrap or halving ops.

Test Plan:
- ADD64: a=0x0000_0000_FFFF_FFFF, b=0x0000_0000_0000_0001 -> writes lo=0x0000_0000 then hi=0x0000_0001. valid_o at cycle 4, ov_set_o=0.
- KADD64: a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> result 0x7FFF_FFFF_FFFF_FFFF, ov_set_o=1. KSUB64 with a=0x8000_0000_0000_0000, b=1 -> 0x8000_0000_0000_0000, ov_set_o=1.
- UKSUB64: a=5, b=7 -> 0, ov_set_o=1. UKADD64 with a=0xFFFF_FFFF_FFFF_FFFF, b=2 -> all-ones, ov_set_o=1.
- RADD64: a=0x8000_0000_0000_0000, b=0x8000_0000_0000_0000 -> 0x8000_0000_0000_0000. URADD64 with the same operands -> 0x8000_0000_0000_0000. RSUB64 with a=0, b=1 -> 0xFFFF_FFFF_FFFF_FFFF.
- wb_ready_i low for 3 cycles in WB_LO -> rf_wdata_o and rf_hi_sel_o held stable, busy_o=1. flush_i in HI -> IDLE next cycle, no rf_we_o.
- en_i with ZPN_SMAR64, or RADD64 with SupportHalving=0 -> illegal_o=1, busy_o stays 0. rst_i asserted in WB_HI -> no valid_o, all outputs 0 next cycle.
